// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction fetch with PC, IF/ID register, stall hold buffer,
//            flush redirect and bubble insertion.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic [31:0] Jump_Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid,
    output logic [4:0]  IFID_Register1,
    output logic [4:0]  IFID_Register2
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_hold;

    logic [31:0] w_pc_next;
    logic [31:0] w_ifid_pc_next;
    logic [31:0] w_ifid_instr_next;
    logic        w_ifid_valid_next;
    logic [31:0] w_hold_next;

    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_jump_pc;
    logic        w_unused_jt;

    assign w_advance   = PCWrite & IFIDWrite;
    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_jump_pc   = {Jump_Target[31:2], 2'b00};
    // Redirect targets are forced word aligned, so the low bits are dropped.
    assign w_unused_jt = &{1'b0, Jump_Target[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_ifid_pc    <= RESET_PC;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
            r_hold       <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_ifid_pc    <= w_ifid_pc_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_valid <= w_ifid_valid_next;
            r_hold       <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_ifid_pc_next    = r_ifid_pc;
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_valid_next = r_ifid_valid;
        w_hold_next       = r_hold;
        imem_req          = 1'b0;

        case (r_state)
            BOOT: begin
                w_state_next = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (Flush) begin
                    w_pc_next         = w_jump_pc;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                end else if (imem_ready) begin
                    if (w_advance) begin
                        w_pc_next         = w_pc_plus4;
                        w_ifid_pc_next    = r_pc;
                        w_ifid_instr_next = imem_rdata;
                        w_ifid_valid_next = 1'b1;
                    end else begin
                        // Word was accepted but the pipe is stalled: park it.
                        w_hold_next  = imem_rdata;
                        w_state_next = HOLD;
                    end
                end else if (IFIDWrite) begin
                    w_ifid_pc_next    = r_pc;
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (Flush) begin
                    w_hold_next       = 32'd0;
                    w_pc_next         = w_jump_pc;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_instr_next = NOP_INSTR;
                    w_ifid_valid_next = 1'b0;
                    w_state_next      = FETCH;
                end else if (w_advance) begin
                    w_pc_next         = w_pc_plus4;
                    w_ifid_pc_next    = r_pc;
                    w_ifid_instr_next = r_hold;
                    w_ifid_valid_next = 1'b1;
                    w_state_next      = FETCH;
                end
            end

            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

    assign imem_addr      = r_pc;
    assign IFID_PC        = r_ifid_pc;
    assign IFID_Instr     = r_ifid_instr;
    assign IFID_Valid     = r_ifid_valid;
    assign IFID_Register1 = r_ifid_instr[19:15];
    assign IFID_Register2 = r_ifid_instr[24:20];

endmodule
`default_nettype wire
